// File: rtl/gpu_pix_pkg.sv
// Shared pixel-pipeline constants and the quad scheduler state encoding.
// A quad is four pixels, so one quad occupies the serializer for QUAD_PIX cycles.
package gpu_pix_pkg;

    localparam int QUAD_PIX     = 4;
    localparam int HOLD_CYCLES  = QUAD_PIX - 1;
    localparam int FLUSH_CYCLES = QUAD_PIX + 1;
    localparam int PHASE_W      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } sched_state_e;

endpackage

// File: rtl/quad_issue_scheduler_if.sv
// Requester-side and serializer-side bundle of the quad issue scheduler.
// The master drives frame control and requester data; the slave is the scheduler.
interface quad_issue_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                   start;
    logic [CNT_W-1:0]       cfg_quad_count;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_R;
    logic [NUM_REQ*32-1:0]  req_G;
    logic [NUM_REQ*32-1:0]  req_B;
    logic                   valid_quad;
    logic [31:0]            R_quad;
    logic [31:0]            G_quad;
    logic [31:0]            B_quad;
    logic [IDX_W-1:0]       grant_id;
    logic                   busy;
    logic                   frame_done;

    modport master (
        output start, cfg_quad_count, req_valid, req_R, req_G, req_B,
        input  req_ready, valid_quad, R_quad, G_quad, B_quad, grant_id, busy, frame_done
    );

    modport slave (
        input  start, cfg_quad_count, req_valid, req_R, req_G, req_B,
        output req_ready, valid_quad, R_quad, G_quad, B_quad, grant_id, busy, frame_done
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// NUM_REQ is a power of two, so the index sum wraps naturally in IDX_W bits.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan from ptr upward; only the first hit latches idx and its grant bit.
    always_comb begin
        logic [IDX_W-1:0] w_pos;
        logic             w_hit;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        w_pos = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos        = ptr + k[IDX_W-1:0];
            w_hit        = req[w_pos] & ~any;
            grant[w_pos] = grant[w_pos] | w_hit;
            idx          = w_hit ? w_pos : idx;
            any          = any | w_hit;
        end
    end

endmodule

// File: rtl/quad_issue_scheduler.sv
// Frame-level quad scheduler: round-robin grants one quad per serializer slot
// and pulses frame_done after the last quad has drained.
module quad_issue_scheduler
    import gpu_pix_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    quad_issue_scheduler_if.slave bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e         r_state;
    logic [PHASE_W-1:0]   r_phase;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]     r_xfer_cnt;
    logic [CNT_W-1:0]     r_cfg;
    logic                 r_valid_quad;
    logic [31:0]          r_r_quad;
    logic [31:0]          r_g_quad;
    logic [31:0]          r_b_quad;
    logic [IDX_W-1:0]     r_grant_id;
    logic                 r_busy;
    logic                 r_frame_done;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic [CNT_W-1:0]     w_xfer_next;
    logic [31:0]          w_r_sel;
    logic [31:0]          w_g_sel;
    logic [31:0]          w_b_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .any   (w_any)
    );

    assign w_xfer_next = r_xfer_cnt + CNT_W'(1);
    assign w_r_sel     = bus.req_R[int'(w_idx)*32 +: 32];
    assign w_g_sel     = bus.req_G[int'(w_idx)*32 +: 32];
    assign w_b_sel     = bus.req_B[int'(w_idx)*32 +: 32];

    // Ready must answer valid in the same cycle, so it is decoded from state, not registered.
    always_comb begin
        if (r_state == ARB) begin
            bus.req_ready = w_grant;
        end else begin
            bus.req_ready = '0;
        end
    end

    assign bus.valid_quad = r_valid_quad;
    assign bus.R_quad     = r_r_quad;
    assign bus.G_quad     = r_g_quad;
    assign bus.B_quad     = r_b_quad;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

    // Frame FSM with registered strobes; r_phase times both HOLD and FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_phase      <= '0;
            r_rr_ptr     <= '0;
            r_xfer_cnt   <= '0;
            r_cfg        <= '0;
            r_valid_quad <= 1'b0;
            r_r_quad     <= 32'd0;
            r_g_quad     <= 32'd0;
            r_b_quad     <= 32'd0;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_quad <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_frame_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    // Busy stays high through the frame_done cycle, which blocks a restart there.
                    if (bus.start && !r_busy) begin
                        r_busy     <= 1'b1;
                        r_cfg      <= bus.cfg_quad_count;
                        r_xfer_cnt <= '0;
                        if (bus.cfg_quad_count == '0) begin
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state <= ARB;
                        end
                    end
                end
                ARB: begin
                    if (w_any) begin
                        r_valid_quad <= 1'b1;
                        r_r_quad     <= w_r_sel;
                        r_g_quad     <= w_g_sel;
                        r_b_quad     <= w_b_sel;
                        r_grant_id   <= w_idx;
                        r_rr_ptr     <= w_idx + IDX_W'(1);
                        r_xfer_cnt   <= w_xfer_next;
                        r_phase      <= '0;
                        if (w_xfer_next == r_cfg) begin
                            r_state <= FLUSH;
                        end else begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (r_phase == PHASE_W'(HOLD_CYCLES - 1)) begin
                        r_state <= ARB;
                    end else begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end
                end
                FLUSH: begin
                    if (r_phase == PHASE_W'(FLUSH_CYCLES - 1)) begin
                        r_state      <= IDLE;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_issue_scheduler.sv
// Directed and randomized frames checked cycle by cycle against a timeline model
// derived from the grant rules: quad k of a frame is granted at cycle 1+delay+4k.
module tb_quad_issue_scheduler;

    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;
    localparam int IDX_W   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quad_issue_scheduler_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    quad_issue_scheduler #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    int          m_ptr;
    logic [31:0] m_gid;
    logic [31:0] m_r;
    logic [31:0] m_g;
    logic [31:0] m_b;
    logic [31:0] dat_r [NUM_REQ];
    logic [31:0] dat_g [NUM_REQ];
    logic [31:0] dat_b [NUM_REQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic load_data(input bit randomize_it);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (randomize_it) begin
                dat_r[i] = $urandom;
                dat_g[i] = $urandom;
                dat_b[i] = $urandom;
            end
            bus.req_R[i*32 +: 32] = dat_r[i];
            bus.req_G[i*32 +: 32] = dat_g[i];
            bus.req_B[i*32 +: 32] = dat_b[i];
        end
    endtask

    task automatic check_outputs(input string tag, input logic exp_valid, input logic [NUM_REQ-1:0] exp_ready,
                                 input logic exp_busy, input logic exp_done);
        chk({tag, ".valid_quad"}, 32'(bus.valid_quad), 32'(exp_valid));
        chk({tag, ".req_ready"},  32'(bus.req_ready),  32'(exp_ready));
        chk({tag, ".busy"},       32'(bus.busy),       32'(exp_busy));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(exp_done));
        chk({tag, ".grant_id"},   32'(bus.grant_id),   m_gid);
        chk({tag, ".R_quad"},     bus.R_quad,          m_r);
        chk({tag, ".G_quad"},     bus.G_quad,          m_g);
        chk({tag, ".B_quad"},     bus.B_quad,          m_b);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            bus.start     = 1'b0;
            bus.req_valid = '1;
            @(negedge clk);
            check_outputs(tag, 1'b0, '0, 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    // One frame: start at cycle 0, requesters silent through cycle dly, optional
    // extra start at cycle stray_at, optional reset pulse at cycle rst_at.
    task automatic run_frame(input string tag, input logic [NUM_REQ-1:0] mask, input int cfg, input int dly,
                             input int stray_at, input int rst_at, input bit rand_data);
        int xc[$];
        int gq[$];
        int fd;
        int g;
        logic             exp_valid;
        logic [NUM_REQ-1:0] exp_ready;
        load_data(rand_data);
        for (int k = 0; k < cfg; k++) begin
            g = -1;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (g < 0 && mask[(m_ptr + j) % NUM_REQ]) g = (m_ptr + j) % NUM_REQ;
            end
            gq.push_back(g);
            xc.push_back(1 + dly + 4 * k);
            m_ptr = (g + 1) % NUM_REQ;
        end
        fd = (cfg == 0) ? 1 : (4 * cfg + dly + 3);
        for (int c = 0; c <= fd + 2; c++) begin
            bus.start          = (c == 0) || (c == stray_at);
            bus.cfg_quad_count = (c == 0) ? CNT_W'(cfg) : CNT_W'($urandom_range(0, 9));
            bus.req_valid      = (c > dly) ? mask : '0;
            rst                = (c == rst_at);
            @(negedge clk);
            exp_valid = 1'b0;
            exp_ready = '0;
            for (int k = 0; k < xc.size(); k++) begin
                if (xc[k] == c) exp_ready[gq[k]] = 1'b1;
                if (xc[k] + 1 == c) begin
                    exp_valid = 1'b1;
                    m_gid     = 32'(gq[k]);
                    m_r       = dat_r[gq[k]];
                    m_g       = dat_g[gq[k]];
                    m_b       = dat_b[gq[k]];
                end
            end
            check_outputs(tag, exp_valid, exp_ready, (c >= 1) && (c <= fd), c == fd);
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                rst   = 1'b0;
                m_ptr = 0;
                m_gid = 32'd0;
                m_r   = 32'd0;
                m_g   = 32'd0;
                m_b   = 32'd0;
                idle_check({tag, ".after_rst"}, 6);
                return;
            end
        end
    endtask

    initial begin
        int cfg;
        bus.start          = 1'b0;
        bus.cfg_quad_count = '0;
        bus.req_valid      = '0;
        bus.req_R          = '0;
        bus.req_G          = '0;
        bus.req_B          = '0;
        m_ptr = 0;
        m_gid = 32'd0;
        m_r   = 32'd0;
        m_g   = 32'd0;
        m_b   = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dat_r[i] = 32'd0;
            dat_g[i] = 32'd0;
            dat_b[i] = 32'd0;
        end

        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check("post_reset", 2);

        run_frame("all_valid_cfg8", 4'b1111, 8, 0, -1, -1, 1'b1);
        run_frame("single_req0_cfg3", 4'b0001, 3, 0, -1, -1, 1'b1);
        run_frame("cfg0_stray_in_done", 4'b1111, 0, 0, 1, -1, 1'b1);
        idle_check("cfg0_quiet", 3);

        for (int i = 0; i < NUM_REQ; i++) begin
            dat_r[i] = $urandom;
            dat_g[i] = $urandom;
            dat_b[i] = $urandom;
        end
        dat_r[0] = 32'hAABBCCDD;
        run_frame("mask0101", 4'b0101, 4, 0, -1, -1, 1'b0);

        run_frame("stray_mid", 4'b1011, 5, 0, 7, -1, 1'b1);
        run_frame("stray_at_done", 4'b0110, 2, 0, 11, -1, 1'b1);
        run_frame("arb_wait", 4'b0100, 2, 6, -1, -1, 1'b1);
        run_frame("rst_in_hold", 4'b1111, 4, 0, -1, 3, 1'b1);
        run_frame("after_rst_frame", 4'b1111, 2, 0, -1, -1, 1'b1);

        for (int n = 0; n < 20; n++) begin
            cfg = $urandom_range(0, 6);
            run_frame("random", 4'($urandom_range(1, 15)), cfg, $urandom_range(0, 3),
                      (cfg == 0) ? 1 : $urandom_range(1, 8), -1, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_issue_scheduler.md
QUAD_ISSUE_SCHEDULER -- requirements
Module: quad_issue_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of quad requesters (power of two, 2..8).
REQ-002 Parameter CNT_W, default 16, width of the per-frame quad counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a frame.
REQ-006 cfg_quad_count  input  CNT_W  quads in frame; sampled only on an accepted start.
REQ-007 req_valid  input  NUM_REQ  per-requester quad available.
REQ-008 req_ready  output  NUM_REQ  per-requester accept; transfer occurs when valid and ready are both high.
REQ-009 req_R, req_G, req_B  input  NUM_REQ*32 each  flattened quads; requester i occupies bits [32i+31:32i].
REQ-010 valid_quad  output  1  quad strobe to the pixel serializer.
REQ-011 R_quad, G_quad, B_quad  output  32 each  quad data; byte [31:24] is pixel 0.
REQ-012 grant_id  output  log2(NUM_REQ)  source of the current quad.
REQ-013 busy  output  1  high from accepted start until frame_done inclusive.
REQ-014 frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-015 The FSM SHALL have states IDLE, ARB, HOLD, FLUSH.
REQ-016 IDLE: start with cfg_quad_count>0 -> ARB; start with cfg_quad_count==0 -> frame_done pulse next cycle, remain IDLE.
REQ-017 ARB: if any req_valid, the block SHALL grant the first valid requester searching from rr_ptr upward, with wrap-around, and drive req_ready high for that requester only, in the same cycle.
REQ-018 req_ready SHALL be low in every state except ARB, and at most one bit SHALL be high.
REQ-019 On a transfer, the block SHALL register the granted data into R/G/B_quad and drive valid_quad high for exactly the next cycle, with grant_id equal to the granted index.
REQ-020 On a transfer, rr_ptr SHALL become (granted index + 1) mod NUM_REQ.
REQ-021 After a transfer, the FSM SHALL enter HOLD for exactly 3 cycles, then return to ARB.
REQ-022 The minimum spacing between valid_quad pulses SHALL be therefore 4 cycles, matching the 4-pixel serializer.
REQ-023 In ARB with no req_valid, the FSM SHALL wait indefinitely with valid_quad low.
REQ-024 When the transfer count reaches the latched cfg_quad_count, the FSM SHALL go to FLUSH instead of HOLD.
REQ-025 frame_done SHALL pulse exactly 5 cycles after the last valid_quad cycle; the FSM then returns to IDLE.
REQ-026 start SHALL be ignored while busy, including in the frame_done cycle.
REQ-027 R/G/B_quad and grant_id SHALL hold their last values when valid_quad is low.
REQ-028 Requesters SHALL NOT make req_valid depend combinationally on req_ready.

Reset
REQ-029 On rst the block SHALL go to IDLE and set rr_ptr=0, transfer count=0, valid_quad=0, R/G/B_quad=0, grant_id=0, busy=0, frame_done=0, and req_ready=0.
REQ-030 Reset mid-frame SHALL discard any in-flight quad; no valid_quad or frame_done SHALL follow until a new start.

Structure
REQ-031 Shared package gpu_pix_pkg SHALL hold QUAD_PIX=4, HOLD_CYCLES=QUAD_PIX-1, FLUSH_CYCLES=QUAD_PIX+1, and the state enum.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs one-hot grant, index, and any).

Verification
REQ-033 Only req_valid[0] high, cfg=3, start at cycle 0 -> valid_quad at cycles 2, 6, 10; frame_done at cycle 15.
REQ-034 All four req_valid held high, cfg=8 -> grant_id sequence 0,1,2,3,0,1,2,3, with spacing of exactly 4 cycles.
REQ-035 cfg=0 start -> frame_done one cycle later; req_ready never asserted; busy is a one-cycle pulse.
REQ-036 req_valid=4'b0101, with requester 0 quad R=0xAABBCCDD -> R_quad=0xAABBCCDD, and grants alternate 0,2.
REQ-037 rst asserted during HOLD -> next cycle all outputs are zero and busy=0; a new start grants requester 0 first.
REQ-038 A second start pulse mid-frame -> ignored; frame_done occurs exactly once, at the original count.
